// File: rtl/pipe_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipe_pkg : shared constants and types for the IF/ID/EX operand stage |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
package pipe_pkg;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  localparam int          CNT_W    = 16;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_EXE = 2'b01,
    FWD_MEM = 2'b10,
    FWD_LD  = 2'b11
  } fwd_sel_e;

  // Event counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

endpackage
`default_nettype wire

// File: rtl/fwd_mux.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fwd_mux : 4:1 operand source select (regfile / EXE / MEM / load)     |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module fwd_mux
  import pipe_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [1:0]      i_sel,
  input  logic [XLEN-1:0] i_rf_data,
  input  logic [XLEN-1:0] i_exe_data,
  input  logic [XLEN-1:0] i_mem_data,
  input  logic [XLEN-1:0] i_ld_data,
  output logic [XLEN-1:0] o_data
);

  always_comb begin
    o_data = i_rf_data;
    case (fwd_sel_e'(i_sel))
      FWD_RF:  o_data = i_rf_data;
      FWD_EXE: o_data = i_exe_data;
      FWD_MEM: o_data = i_mem_data;
      FWD_LD:  o_data = i_ld_data;
      default: o_data = i_rf_data;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/id_ex_operand_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | id_ex_operand_stage : IF/ID and ID/EX registers with operand forwarding|
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module id_ex_operand_stage #(
  parameter int          XLEN     = 32,
  parameter logic [31:0] NOP_INST = pipe_pkg::NOP_INST
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] PC_IF,
  input  logic [XLEN-1:0] inst_IF,
  input  logic            valid_IF,
  input  logic            reg_FD_EN,
  input  logic            reg_FD_stall,
  input  logic            reg_FD_flush,
  input  logic            reg_DE_EN,
  input  logic            reg_DE_flush,
  input  logic [1:0]      forward_ctrl_A,
  input  logic [1:0]      forward_ctrl_B,
  input  logic            forward_ctrl_ls,
  input  logic [XLEN-1:0] rs1_data_ID,
  input  logic [XLEN-1:0] rs2_data_ID,
  input  logic [4:0]      rd_ID,
  input  logic [XLEN-1:0] ALUout_EXE,
  input  logic [XLEN-1:0] ALUout_MEM,
  input  logic [XLEN-1:0] Datain_MEM,
  output logic [XLEN-1:0] PC_ID,
  output logic [XLEN-1:0] inst_ID,
  output logic            valid_ID,
  output logic [XLEN-1:0] PC_EXE,
  output logic [XLEN-1:0] rs1_val_EXE,
  output logic [XLEN-1:0] rs2_val_EXE,
  output logic [XLEN-1:0] st_data_EXE,
  output logic [4:0]      rd_EXE_o,
  output logic            valid_EXE,
  output logic [15:0]     stall_cnt,
  output logic [15:0]     flush_cnt
);

  import pipe_pkg::CNT_W;
  import pipe_pkg::sat_inc;

  localparam logic [XLEN-1:0] C_NOP = XLEN'(NOP_INST);

  logic [XLEN-1:0]  pc_id_q,   pc_id_d;
  logic [XLEN-1:0]  inst_id_q, inst_id_d;
  logic             valid_id_q, valid_id_d;
  logic [XLEN-1:0]  pc_ex_q,   pc_ex_d;
  logic [XLEN-1:0]  rs1_ex_q,  rs1_ex_d;
  logic [XLEN-1:0]  rs2_ex_q,  rs2_ex_d;
  logic [XLEN-1:0]  st_ex_q,   st_ex_d;
  logic [4:0]       rd_ex_q,   rd_ex_d;
  logic             valid_ex_q, valid_ex_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic [XLEN-1:0]  w_op_a;
  logic [XLEN-1:0]  w_op_b;
  logic             w_fd_hold;

  fwd_mux #(.XLEN(XLEN)) u_fwd_a (
    .i_sel      (forward_ctrl_A),
    .i_rf_data  (rs1_data_ID),
    .i_exe_data (ALUout_EXE),
    .i_mem_data (ALUout_MEM),
    .i_ld_data  (Datain_MEM),
    .o_data     (w_op_a)
  );

  fwd_mux #(.XLEN(XLEN)) u_fwd_b (
    .i_sel      (forward_ctrl_B),
    .i_rf_data  (rs2_data_ID),
    .i_exe_data (ALUout_EXE),
    .i_mem_data (ALUout_MEM),
    .i_ld_data  (Datain_MEM),
    .o_data     (w_op_b)
  );

  assign w_fd_hold = reg_FD_stall || !reg_FD_EN;

  always_comb begin
    pc_id_d     = pc_id_q;
    inst_id_d   = inst_id_q;
    valid_id_d  = valid_id_q;
    pc_ex_d     = pc_ex_q;
    rs1_ex_d    = rs1_ex_q;
    rs2_ex_d    = rs2_ex_q;
    st_ex_d     = st_ex_q;
    rd_ex_d     = rd_ex_q;
    valid_ex_d  = valid_ex_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;

    // Flush keeps the PC so the killed slot still reports where it came from.
    if (reg_FD_flush) begin
      inst_id_d  = C_NOP;
      valid_id_d = 1'b0;
    end else if (!w_fd_hold) begin
      pc_id_d    = PC_IF;
      inst_id_d  = inst_IF;
      valid_id_d = valid_IF;
    end

    // A decode stall must inject a bubble so the held instruction is not issued twice.
    if (reg_DE_flush || reg_FD_stall) begin
      valid_ex_d = 1'b0;
      rd_ex_d    = 5'd0;
    end else if (reg_DE_EN) begin
      pc_ex_d    = pc_id_q;
      rd_ex_d    = rd_ID;
      valid_ex_d = valid_id_q;
      rs1_ex_d   = w_op_a;
      rs2_ex_d   = w_op_b;
      st_ex_d    = forward_ctrl_ls ? Datain_MEM : w_op_b;
    end

    if (w_fd_hold && valid_id_q && !reg_FD_flush)
      stall_cnt_d = sat_inc(stall_cnt_q);
    if (reg_FD_flush || reg_DE_flush)
      flush_cnt_d = sat_inc(flush_cnt_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_id_q     <= '0;
      inst_id_q   <= C_NOP;
      valid_id_q  <= 1'b0;
      pc_ex_q     <= '0;
      rs1_ex_q    <= '0;
      rs2_ex_q    <= '0;
      st_ex_q     <= '0;
      rd_ex_q     <= 5'd0;
      valid_ex_q  <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      pc_id_q     <= pc_id_d;
      inst_id_q   <= inst_id_d;
      valid_id_q  <= valid_id_d;
      pc_ex_q     <= pc_ex_d;
      rs1_ex_q    <= rs1_ex_d;
      rs2_ex_q    <= rs2_ex_d;
      st_ex_q     <= st_ex_d;
      rd_ex_q     <= rd_ex_d;
      valid_ex_q  <= valid_ex_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign PC_ID       = pc_id_q;
  assign inst_ID     = inst_id_q;
  assign valid_ID    = valid_id_q;
  assign PC_EXE      = pc_ex_q;
  assign rs1_val_EXE = rs1_ex_q;
  assign rs2_val_EXE = rs2_ex_q;
  assign st_data_EXE = st_ex_q;
  assign rd_EXE_o    = rd_ex_q;
  assign valid_EXE   = valid_ex_q;
  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;

endmodule
`default_nettype wire

// File: doc/id_ex_operand_stage.md
ID_EX_OPERAND_STAGE -- requirements
Module: id_ex_operand_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width.
REQ-002 SHALL have parameter NOP_INST, default 32'h00000013, instruction injected on IF/ID flush.
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports PC_IF, inst_IF  input  XLEN  fetched PC and instruction.
REQ-006 SHALL have port valid_IF  input  1  fetch slot holds a real instruction.
REQ-007 SHALL have ports reg_FD_EN, reg_FD_stall, reg_FD_flush, reg_DE_EN, reg_DE_flush  input  1 each  pipeline controls from hazard unit.
REQ-008 SHALL have ports forward_ctrl_A, forward_ctrl_B  input  2 each  operand source select; forward_ctrl_ls  input  1  store-data select.
REQ-009 SHALL have ports rs1_data_ID, rs2_data_ID  input  XLEN  register-file read data; rd_ID  input  5  destination.
REQ-010 SHALL have ports ALUout_EXE, ALUout_MEM, Datain_MEM  input  XLEN  forwarding sources.
REQ-011 SHALL have ports PC_ID, inst_ID  output  XLEN; valid_ID  output  1  IF/ID register contents.
REQ-012 SHALL have ports PC_EXE, rs1_val_EXE, rs2_val_EXE, st_data_EXE  output  XLEN; rd_EXE_o  output  5; valid_EXE  output  1  ID/EX register contents.
REQ-013 SHALL have ports stall_cnt, flush_cnt  output  16  saturating event counters.

Function
REQ-014 IF/ID update priority SHALL be: reg_FD_flush > (reg_FD_stall or !reg_FD_EN) hold > load.
REQ-015 IF/ID flush SHALL load inst_ID=NOP_INST, valid_ID=0, PC_ID unchanged, next edge.
REQ-016 IF/ID load SHALL capture PC_IF, inst_IF, valid_IF with 1-cycle latency.
REQ-017 ID/EX update priority SHALL be: reg_DE_flush > reg_FD_stall bubble > !reg_DE_EN hold > load.
REQ-018 ID/EX flush or bubble SHALL set valid_EXE=0, rd_EXE_o=0; data fields SHALL hold.
REQ-019 ID/EX load SHALL capture PC_ID, rd_ID, valid_ID and forwarded operands, 1-cycle latency.
REQ-020 Operand select SHALL be 00 regfile data, 01 ALUout_EXE, 10 ALUout_MEM, 11 Datain_MEM, independently for A and B.
REQ-021 st_data_EXE SHALL capture Datain_MEM when forward_ctrl_ls=1, else the B-selected operand.
REQ-022 Forward selects SHALL be sampled combinationally in the same cycle as the ID/EX load; no extra register stage.
REQ-023 stall_cnt SHALL increment by 1 per edge where IF/ID holds while valid_ID=1 and no flush.
REQ-024 flush_cnt SHALL increment by 1 per edge where reg_FD_flush or reg_DE_flush is 1 (both together count once).
REQ-025 Both counters SHALL saturate at 16'hFFFF, never wrap.
REQ-026 Simultaneous reg_FD_flush and reg_FD_stall SHALL flush IF/ID and bubble ID/EX.
REQ-027 X on forward selects while ID/EX holds or bubbles SHALL NOT alter captured data.

Reset
REQ-028 rst_n low SHALL immediately force PC_ID=0, inst_ID=NOP_INST, valid_ID=0.
REQ-029 rst_n low SHALL immediately force PC_EXE, rs1_val_EXE, rs2_val_EXE, st_data_EXE=0, rd_EXE_o=0, valid_EXE=0, counters=0.
REQ-030 Reset asserted mid-stall SHALL discard held contents; first edge after release SHALL perform a normal load.

Structure
REQ-031 Shared package pipe_pkg SHALL hold NOP_INST, forward-select encodings FWD_RF/FWD_EXE/FWD_MEM/FWD_LD, counter width.
REQ-032 One sub-module fwd_mux (XLEN 4:1 select) SHALL be instantiated twice for operands A and B.

Verification
REQ-033 Reset: rst_n=0 mid-cycle -> all outputs zero, inst_ID=32'h00000013, without clock edge.
REQ-034 Load: PC_IF=0x100, inst_IF=0x00500093, valid_IF=1 -> next edge PC_ID=0x100, valid_ID=1; following edge PC_EXE=0x100, valid_EXE=1.
REQ-035 Forwarding: rs1_data_ID=1, ALUout_EXE=0xAA, ALUout_MEM=0xBB, Datain_MEM=0xCC, A=01, B=11 -> rs1_val_EXE=0xAA, rs2_val_EXE=0xCC; ls=1 -> st_data_EXE=0xCC.
REQ-036 Stall: reg_FD_stall=1 for 2 cycles with valid_ID=1 -> PC_ID held, valid_EXE=0 both cycles, stall_cnt=2.
REQ-037 Flush priority: reg_FD_flush=1, reg_FD_stall=1, reg_DE_flush=1 same cycle -> inst_ID=NOP, valid_ID=0, valid_EXE=0, flush_cnt +1.
REQ-038 Saturation: preload counter path by 65537 flush cycles -> flush_cnt=16'hFFFF, remains after further flushes.
